// File: rtl/memory_arb_pkg.sv
// memory_arb_pkg: shared state encoding, owner ids and width defaults for the memory arbiter
package memory_arb_pkg;
  localparam int ADDR_W_DEFAULT = 12;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_PNL = 2'd1;
  localparam logic [1:0] OWN_IO = 2'd2;
  localparam logic [1:0] OWN_PU = 2'd3;
endpackage

// File: rtl/memory_arb_pick.sv
// memory_arb_pick: combinational winner select; panel absolute, IO/PU alternate on last_io_pu
module memory_arb_pick
  import memory_arb_pkg::*;
(
  input  logic       pnl_wr,
  input  logic       pnl_rd,
  input  logic       io_wr,
  input  logic       pu_rd,
  input  logic       last_io_pu,
  output logic [1:0] owner,
  output logic       wr,
  output logic       valid
);
  logic io_win;
  // last_io_pu = 1 means PU went last, so a pending IO takes its turn
  always_comb begin
    io_win = io_wr & (~pu_rd | last_io_pu);
    owner = (pnl_wr | pnl_rd) ? OWN_PNL : io_win ? OWN_IO : pu_rd ? OWN_PU : OWN_NONE;
    wr = pnl_wr | (~pnl_rd & io_win);
    valid = pnl_wr | pnl_rd | io_wr | pu_rd;
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: sequences the single-port core memory among panel, IO and PU with a reply watchdog
module memory_arbiter
  import memory_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pnl_rd_req,
  input  logic              pnl_wr_req,
  input  logic [ADDR_W-1:0] pnl_addr,
  output logic              pnl_ack,
  input  logic              io_wr_req,
  input  logic [ADDR_W-1:0] io_addr,
  output logic              io_ack,
  input  logic              pu_rd_req,
  input  logic [ADDR_W-1:0] pu_addr,
  output logic              pu_ack,
  output logic              mem_read_from_pu,
  output logic              mem_read_from_pnl,
  output logic              mem_write_from_io,
  output logic              mem_write_from_pnl,
  output logic [ADDR_W-1:0] sel_value_to_sel,
  output logic              wdata_src,
  input  logic              mem_read_reply,
  input  logic              mem_write_reply,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              timeout_err,
  input  logic              err_clr
);
  logic [1:0] state;
  logic [1:0] owner;
  logic       wr;
  logic       last_io_pu;
  logic [7:0] cnt;
  logic [1:0] pick_owner;
  logic       pick_wr;
  logic       pick_valid;
  logic [ADDR_W-1:0] pick_addr;
  logic       reply;
  logic       expire;
  memory_arb_pick u_pick (
    .pnl_wr(pnl_wr_req),
    .pnl_rd(pnl_rd_req),
    .io_wr(io_wr_req),
    .pu_rd(pu_rd_req),
    .last_io_pu(last_io_pu),
    .owner(pick_owner),
    .wr(pick_wr),
    .valid(pick_valid)
  );
  // strobes and acks are decoded from the registered state and latched owner/kind
  always_comb begin
    pick_addr = pick_owner == OWN_PNL ? pnl_addr : pick_owner == OWN_IO ? io_addr : pu_addr;
    reply = wr ? mem_write_reply : mem_read_reply;
    expire = state == S_WAIT && !reply && cnt == 8'(TIMEOUT - 1);
    mem_read_from_pu = state == S_ISSUE && owner == OWN_PU;
    mem_read_from_pnl = state == S_ISSUE && owner == OWN_PNL && !wr;
    mem_write_from_pnl = state == S_ISSUE && owner == OWN_PNL && wr;
    mem_write_from_io = state == S_ISSUE && owner == OWN_IO;
    pnl_ack = state == S_DONE && owner == OWN_PNL;
    io_ack = state == S_DONE && owner == OWN_IO;
    pu_ack = state == S_DONE && owner == OWN_PU;
    busy = state != S_IDLE;
    grant_id = busy ? owner : OWN_NONE;
  end
  // transaction sequencer, watchdog, fairness bit and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      owner <= OWN_NONE;
      wr <= 1'b0;
      last_io_pu <= 1'b0;
      cnt <= 8'd0;
      sel_value_to_sel <= '0;
      wdata_src <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire | (timeout_err & ~err_clr);
      case (state)
        S_IDLE: if (pick_valid) begin
          state <= S_ISSUE;
          owner <= pick_owner;
          wr <= pick_wr;
          sel_value_to_sel <= pick_addr;
          wdata_src <= pick_owner == OWN_PNL;
        end
        S_ISSUE: begin
          state <= S_WAIT;
          cnt <= 8'd0;
        end
        S_WAIT: begin
          state <= reply ? S_DONE : expire ? S_IDLE : S_WAIT;
          cnt <= cnt + 8'd1;
        end
        default: begin
          state <= S_IDLE;
          last_io_pu <= owner == OWN_PU ? 1'b1 : owner == OWN_IO ? 1'b0 : last_io_pu;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench with a reply-latency memory model and a priority/fairness reference model
module tb_memory_arbiter;
  typedef struct {
    logic [1:0]  own;
    logic        wr;
    logic [11:0] addr;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pnl_rd_req = 1'b0, pnl_wr_req = 1'b0, io_wr_req = 1'b0, pu_rd_req = 1'b0;
  logic [11:0] pnl_addr = '0, io_addr = '0, pu_addr = '0;
  logic pnl_ack, io_ack, pu_ack;
  logic mem_read_from_pu, mem_read_from_pnl, mem_write_from_io, mem_write_from_pnl;
  logic [11:0] sel_value_to_sel;
  logic wdata_src, busy, timeout_err;
  logic [1:0] grant_id;
  logic mem_read_reply = 1'b0, mem_write_reply = 1'b0;
  logic err_clr = 1'b0;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int ack_count = 0;
  int req_cyc = 0;
  int mode = 0;
  bit pu_fav = 1'b1;
  ent_t exp_q[$];

  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .pnl_rd_req(pnl_rd_req), .pnl_wr_req(pnl_wr_req), .pnl_addr(pnl_addr), .pnl_ack(pnl_ack),
    .io_wr_req(io_wr_req), .io_addr(io_addr), .io_ack(io_ack),
    .pu_rd_req(pu_rd_req), .pu_addr(pu_addr), .pu_ack(pu_ack),
    .mem_read_from_pu(mem_read_from_pu), .mem_read_from_pnl(mem_read_from_pnl),
    .mem_write_from_io(mem_write_from_io), .mem_write_from_pnl(mem_write_from_pnl),
    .sel_value_to_sel(sel_value_to_sel), .wdata_src(wdata_src),
    .mem_read_reply(mem_read_reply), .mem_write_reply(mem_write_reply),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    int s_cyc, lat, last_ack, exp_s;
    logic [1:0] own, cur_own;
    logic [11:0] cur_addr;
    logic w;
    bit cur;
    ent_t e;
    last_ack = -10;
    cur = 0;
    lat = 0;
    s_cyc = 0;
    cur_own = 0;
    cur_addr = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cur = 0;
        continue;
      end
      chk("single_strobe", $countones({mem_read_from_pu, mem_read_from_pnl, mem_write_from_io, mem_write_from_pnl}) <= 1, 1);
      if (mem_read_from_pu | mem_read_from_pnl | mem_write_from_io | mem_write_from_pnl) begin
        own = mem_read_from_pu ? 2'd3 : mem_write_from_io ? 2'd2 : 2'd1;
        w = mem_write_from_io | mem_write_from_pnl;
        chk("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("strobe_owner", own, e.own);
          chk("strobe_kind", w, e.wr);
          chk("strobe_sel", sel_value_to_sel, e.addr);
          if (w) chk("wdata_src", wdata_src, own == 2'd1);
          chk("grant_id", grant_id, own);
          exp_s = (last_ack + 2 > req_cyc + 1) ? last_ack + 2 : req_cyc + 1;
          chk("strobe_time", cyc, exp_s);
          cur = 1;
          s_cyc = cyc;
          cur_own = own;
          cur_addr = e.addr;
          lat = mode == 1 ? 0 : (mode == 2 && w) ? 4 : 3;
        end
      end
      chk("single_ack", $countones({pnl_ack, io_ack, pu_ack}) <= 1, 1);
      if (pnl_ack | io_ack | pu_ack) begin
        ack_count++;
        chk("ack_has_txn", cur, 1);
        if (cur) begin
          chk("ack_owner", pu_ack ? 3 : io_ack ? 2 : 1, cur_own);
          chk("ack_time", cyc - s_cyc, lat);
          chk("sel_hold_done", sel_value_to_sel, cur_addr);
        end
        cur = 0;
        last_ack = cyc;
      end
    end
  endtask

  task automatic memory_model();
    bit pend, pw;
    int ps, pm;
    pend = 0;
    pw = 0;
    ps = 0;
    pm = 0;
    forever begin
      tick();
      mem_read_reply = 1'b0;
      mem_write_reply = 1'b0;
      if (pend && cyc == ps + 2) begin
        if (pm == 2) mem_read_reply = 1'b1;
        else if (pm == 0) begin
          mem_write_reply = pw;
          mem_read_reply = !pw;
        end
        if (pm != 2) pend = 0;
      end
      if (pend && pm == 2 && cyc == ps + 3) begin
        mem_write_reply = 1'b1;
        pend = 0;
      end
      if (mem_read_from_pu | mem_read_from_pnl | mem_write_from_io | mem_write_from_pnl) begin
        pend = 1;
        ps = cyc;
        pm = mode;
        pw = mem_write_from_io | mem_write_from_pnl;
      end
    end
  endtask

  task automatic batch(input int pw, input int pr, input int io, input int pu,
                       input logic [11:0] pa, input logic [11:0] ia, input logic [11:0] ua);
    int ni, nu;
    if (pw > 0) exp_q.push_back('{2'd1, 1'b1, pa});
    if (pr > 0) exp_q.push_back('{2'd1, 1'b0, pa});
    ni = io;
    nu = pu;
    while (ni + nu > 0) begin
      if (nu > 0 && (ni == 0 || pu_fav)) begin
        exp_q.push_back('{2'd3, 1'b0, ua});
        nu--;
        pu_fav = 0;
      end else begin
        exp_q.push_back('{2'd2, 1'b1, ia});
        ni--;
        pu_fav = 1;
      end
    end
    pnl_addr = pa;
    io_addr = ia;
    pu_addr = ua;
    req_cyc = cyc;
    pnl_wr_req = pw > 0;
    pnl_rd_req = pr > 0;
    io_wr_req = io > 0;
    pu_rd_req = pu > 0;
    ni = io;
    nu = pu;
    for (int k = 0; k < 200 && (pnl_wr_req | pnl_rd_req | io_wr_req | pu_rd_req); k++) begin
      tick();
      if (pnl_ack) begin
        if (pnl_wr_req) pnl_wr_req = 1'b0;
        else pnl_rd_req = 1'b0;
      end
      if (io_ack && --ni <= 0) io_wr_req = 1'b0;
      if (pu_ack && --nu <= 0) pu_rd_req = 1'b0;
    end
    chk("batch_reqs_left", {pnl_wr_req, pnl_rd_req, io_wr_req, pu_rd_req}, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    {pnl_wr_req, pnl_rd_req, io_wr_req, pu_rd_req} = '0;
  endtask

  initial begin
    int a0, seen, c, pw, pr, io, pu;
    logic [11:0] ra;
    fork
      monitor();
      memory_model();
    join_none
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_sel", sel_value_to_sel, 0);
    chk("rst_wdata_src", wdata_src, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_outputs", {pnl_ack, io_ack, pu_ack, mem_read_from_pu, mem_read_from_pnl, mem_write_from_io, mem_write_from_pnl}, 0);
    tick();
    batch(0, 0, 0, 1, 12'h111, 12'h222, 12'h0A5);
    batch(1, 1, 1, 1, 12'h3C3, 12'h444, 12'h555);
    batch(0, 0, 2, 2, 12'h000, 12'h6A6, 12'h7B7);
    tick();
    ra = 12'($urandom);
    exp_q.push_back('{2'd3, 1'b0, ra});
    exp_q.push_back('{2'd3, 1'b0, ra});
    mode = 1;
    pu_addr = ra;
    c = cyc;
    req_cyc = c;
    pu_rd_req = 1'b1;
    a0 = ack_count;
    repeat (16) tick();
    chk("to_err_before", timeout_err, 0);
    chk("to_busy_before", busy, 1);
    tick();
    chk("to_err_set", timeout_err, 1);
    chk("to_busy_after", busy, 0);
    chk("to_no_ack", ack_count, a0);
    mode = 0;
    req_cyc = cyc;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = pu_ack;
    end
    pu_rd_req = 1'b0;
    pu_fav = 0;
    chk("to_regrant_ack", seen, 1);
    chk("to_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", timeout_err, 0);
    mode = 2;
    batch(0, 0, 1, 0, 12'h000, 12'h9E9, 12'h000);
    batch(0, 0, 0, 1, 12'h000, 12'h000, 12'hABC);
    mode = 0;
    repeat (3) tick();
    ra = 12'($urandom);
    exp_q.push_back('{2'd1, 1'b0, ra});
    pnl_addr = ra;
    req_cyc = cyc;
    pnl_rd_req = 1'b1;
    a0 = ack_count;
    tick();
    tick();
    chk("rw_in_wait", busy, 1);
    reset = 1'b1;
    pnl_rd_req = 1'b0;
    tick();
    reset = 1'b0;
    pu_fav = 1;
    chk("rw_busy", busy, 0);
    chk("rw_outputs", {pnl_ack, io_ack, pu_ack, mem_read_from_pu, mem_read_from_pnl, mem_write_from_io, mem_write_from_pnl}, 0);
    repeat (4) tick();
    chk("rw_no_late_ack", ack_count, a0);
    chk("rw_busy_idle", busy, 0);
    for (int b = 0; b < 25; b++) begin
      pw = $urandom_range(0, 1);
      pr = $urandom_range(0, 1);
      io = $urandom_range(0, 2);
      pu = $urandom_range(0, 2);
      if (pw + pr + io + pu == 0) pu = 1;
      mode = $urandom_range(0, 3) == 0 ? 2 : 0;
      batch(pw, pr, io, pu, 12'($urandom), 12'($urandom), 12'($urandom));
    end
    mode = 0;
    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
